fpu_sqrt_sched: RTL

Controller for the shared iterative square-root datapath in the FPU arithmetic cluster. It arbitrates single-precision sqrt requests from two requesters, decodes special operands and answers them without using the datapath, and prepares and sequences the datapath operands (start pulse, subnormal and exponent-parity flags, halved exponent, significand). It then captures the pre-normalised result and returns it to the requester over a valid/ready handshake. Only one operation is in flight at a time.

---
 rtl/fpu_sqrt_sched.sv | 257 +++++++++++++++++++++++++
 1 files changed

// File: rtl/fpu_sqrt_sched.sv
// fpu_sqrt_sched: request arbitration, special-operand decode and sequencing for the
// shared iterative single-precision square-root datapath. One operation in flight.
// Optional watchdog on WAIT/DRAIN: define FPU_SQRT_SCHED_WATCHDOG_EN.
module fpu_sqrt_sched #(
  parameter int unsigned NREQ        = 2,
  parameter int unsigned TAG_W       = 5,
  parameter int unsigned WDOG_CYCLES = 63
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [NREQ-1:0]         req_valid,
  output logic [NREQ-1:0]         req_ready,
  input  logic [32*NREQ-1:0]      req_operand,
  input  logic [3*NREQ-1:0]       req_rm,
  input  logic [NREQ*TAG_W-1:0]   req_tag,
  input  logic                    flush,
  output logic                    sqrt_start,
  output logic                    sqrt_is_subnormal,
  output logic                    sqrt_in_exp0,
  output logic [7:0]              sqrt_exp_half,
  output logic [23:0]             sqrt_in_sig,
  input  logic                    sqrt_done,
  input  logic [26:0]             sqrt_sig,
  input  logic [7:0]              sqrt_exp,
  input  logic                    sqrt_uf,
  output logic                    rsp_valid,
  input  logic                    rsp_ready,
  output logic                    rsp_id,
  output logic [TAG_W-1:0]        rsp_tag,
  output logic [2:0]              rsp_rm,
  output logic [26:0]             rsp_sig,
  output logic [7:0]              rsp_exp,
  output logic                    rsp_uf,
  output logic                    rsp_special,
  output logic [31:0]             rsp_value,
  output logic                    rsp_nv,
  output logic                    busy
`ifdef FPU_SQRT_SCHED_WATCHDOG_EN
  ,
  output logic                    wdog_err
`endif
);

  localparam logic [31:0] QNaN   = 32'h7FC0_0000;
  localparam logic [31:0] PosInf = 32'h7F80_0000;

  typedef enum logic [2:0] {StIdle, StIssue, StWait, StResp, StDrain} state_e;

  state_e             r_state;
  logic               r_ptr;
  logic               r_is_subnormal;
  logic               r_in_exp0;
  logic [7:0]         r_exp_half;
  logic [23:0]        r_in_sig;
  logic               r_rsp_id;
  logic [TAG_W-1:0]   r_rsp_tag;
  logic [2:0]         r_rsp_rm;
  logic [26:0]        r_rsp_sig;
  logic [7:0]         r_rsp_exp;
  logic               r_rsp_uf;
  logic               r_rsp_special;
  logic [31:0]        r_rsp_value;
  logic               r_rsp_nv;

  logic               w_gnt_id;
  logic               w_accept;
  logic [31:0]        w_op;
  logic [TAG_W-1:0]   w_tag;
  logic [2:0]         w_rm;
  logic [7:0]         w_e;
  logic [22:0]        w_f;
  logic               w_is_nan;
  logic               w_is_zero;
  logic               w_is_inf;
  logic               w_special;
  logic [31:0]        w_spec_value;
  logic               w_spec_nv;
  logic [8:0]         w_ee;
  logic [8:0]         w_half_sum;
  logic [7:0]         w_exp_half;

  // Round-robin grant: preferred requester first, otherwise the other one
  always_comb begin
    w_gnt_id = r_ptr;
    if (!req_valid[r_ptr]) begin
      w_gnt_id = ~r_ptr;
    end
  end

  assign w_accept = (r_state == StIdle) && !flush && (|req_valid);

  // One-hot ready to the granted requester only
  always_comb begin
    req_ready = '0;
    if (w_accept) begin
      req_ready[w_gnt_id] = 1'b1;
    end
  end

  assign w_op  = w_gnt_id ? req_operand[63:32] : req_operand[31:0];
  assign w_tag = w_gnt_id ? req_tag[2*TAG_W-1:TAG_W] : req_tag[TAG_W-1:0];
  assign w_rm  = w_gnt_id ? req_rm[5:3] : req_rm[2:0];

  // Special-operand classification and datapath operand preparation
  always_comb begin
    w_e          = w_op[30:23];
    w_f          = w_op[22:0];
    w_is_nan     = (w_e == 8'hFF) && (w_f != '0);
    w_is_zero    = (w_e == 8'h00) && (w_f == '0);
    w_is_inf     = (w_e == 8'hFF) && (w_f == '0);
    w_special    = w_is_nan || w_is_zero || w_is_inf || w_op[31];
    w_spec_value = QNaN;
    w_spec_nv    = 1'b0;
    if (w_is_nan) begin
      w_spec_nv = ~w_f[22];
    end else if (w_is_zero) begin
      w_spec_value = w_op;
    end else if (w_op[31]) begin
      w_spec_nv = 1'b1;
    end else if (w_is_inf) begin
      w_spec_value = PosInf;
    end
    // Subnormals behave as exponent 1 for the halving
    w_ee       = (w_e == 8'h00) ? 9'd1 : {1'b0, w_e};
    w_half_sum = w_ee + 9'd126 + {8'd0, w_ee[0]};
    w_exp_half = 8'(w_half_sum >> 1);
  end

`ifdef FPU_SQRT_SCHED_WATCHDOG_EN
  localparam logic [5:0] WdogLast = 6'(WDOG_CYCLES - 1);
  logic [5:0] r_wdog_cnt;
  logic       r_wdog_err;
  logic       w_wdog_hit;
  assign w_wdog_hit = (r_wdog_cnt == WdogLast);
  assign wdog_err   = r_wdog_err;
`else
  logic w_unused_wdog;
  assign w_unused_wdog = (WDOG_CYCLES != 0);
`endif

  // Control FSM with all operand and response registers
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state        <= StIdle;
      r_ptr          <= 1'b0;
      r_is_subnormal <= 1'b0;
      r_in_exp0      <= 1'b0;
      r_exp_half     <= '0;
      r_in_sig       <= '0;
      r_rsp_id       <= 1'b0;
      r_rsp_tag      <= '0;
      r_rsp_rm       <= '0;
      r_rsp_sig      <= '0;
      r_rsp_exp      <= '0;
      r_rsp_uf       <= 1'b0;
      r_rsp_special  <= 1'b0;
      r_rsp_value    <= '0;
      r_rsp_nv       <= 1'b0;
`ifdef FPU_SQRT_SCHED_WATCHDOG_EN
      r_wdog_cnt     <= '0;
      r_wdog_err     <= 1'b0;
`endif
    end else begin
`ifdef FPU_SQRT_SCHED_WATCHDOG_EN
      r_wdog_err <= 1'b0;
`endif
      unique case (r_state)
        StIdle: begin
          if (w_accept) begin
            r_ptr     <= ~w_gnt_id;
            r_rsp_id  <= w_gnt_id;
            r_rsp_tag <= w_tag;
            r_rsp_rm  <= w_rm;
            if (w_special) begin
              r_rsp_special <= 1'b1;
              r_rsp_value   <= w_spec_value;
              r_rsp_nv      <= w_spec_nv;
              r_state       <= StResp;
            end else begin
              r_is_subnormal <= (w_e == 8'h00);
              r_in_exp0      <= w_e[0];
              r_exp_half     <= w_exp_half;
              r_in_sig       <= {(w_e != 8'h00), w_f};
              r_state        <= StIssue;
            end
          end
        end
        StIssue: begin
`ifdef FPU_SQRT_SCHED_WATCHDOG_EN
          r_wdog_cnt <= '0;
`endif
          r_state <= flush ? StDrain : StWait;
        end
        StWait: begin
          if (flush) begin
            // A result landing together with flush is simply dropped
            r_state <= sqrt_done ? StIdle : StDrain;
          end else if (sqrt_done) begin
            r_rsp_sig     <= sqrt_sig;
            r_rsp_exp     <= sqrt_exp;
            r_rsp_uf      <= sqrt_uf;
            r_rsp_special <= 1'b0;
            r_rsp_nv      <= 1'b0;
            r_state       <= StResp;
          end
`ifdef FPU_SQRT_SCHED_WATCHDOG_EN
          else if (w_wdog_hit) begin
            r_wdog_err <= 1'b1;
            r_state    <= StIdle;
          end
          if (!flush && !sqrt_done) begin
            r_wdog_cnt <= r_wdog_cnt + 6'd1;
          end
`endif
        end
        StResp: begin
          if (flush || rsp_ready) begin
            r_state <= StIdle;
          end
        end
        StDrain: begin
          if (sqrt_done) begin
            r_state <= StIdle;
          end
`ifdef FPU_SQRT_SCHED_WATCHDOG_EN
          else if (w_wdog_hit) begin
            r_wdog_err <= 1'b1;
            r_state    <= StIdle;
          end
          if (!sqrt_done) begin
            r_wdog_cnt <= r_wdog_cnt + 6'd1;
          end
`endif
        end
        default: r_state <= StIdle;
      endcase
    end
  end

  assign sqrt_start        = (r_state == StIssue);
  assign rsp_valid         = (r_state == StResp);
  assign busy              = (r_state != StIdle);
  assign sqrt_is_subnormal = r_is_subnormal;
  assign sqrt_in_exp0      = r_in_exp0;
  assign sqrt_exp_half     = r_exp_half;
  assign sqrt_in_sig       = r_in_sig;
  assign rsp_id            = r_rsp_id;
  assign rsp_tag           = r_rsp_tag;
  assign rsp_rm            = r_rsp_rm;
  assign rsp_sig           = r_rsp_sig;
  assign rsp_exp           = r_rsp_exp;
  assign rsp_uf            = r_rsp_uf;
  assign rsp_special       = r_rsp_special;
  assign rsp_value         = r_rsp_value;
  assign rsp_nv            = r_rsp_nv;

endmodule
